fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised prefetching instruction-fetch unit. It decouples the PC/instruction-memory side from decode through a DEPTH-entry instruction queue.
- Talks to a stalling instruction memory over a req/ack handshake with one outstanding request.
- Supports branch/jump redirect with flush, and stops fetching after a halt instruction.
- Sits between imem and decode in the processor top, replacing the single-cycle fetch.

Parameters:
- WIDTH, 16, instruction and PC width in bits (>= 8, even).
- DEPTH, 4, queue entries; power of 2, >= 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; 0 = reset, sampled on rising clk.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  new fetch address; must be even.
- deq_ready  in  1  decode accepts head entry this cycle.
- out_valid  out  1  head entry valid.
- out_instr  out  WIDTH  head instruction.
- out_pc  out  WIDTH  address of head instruction.
- out_pc_next  out  WIDTH  out_pc + 2, wrapping mod 2^WIDTH.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  WIDTH  request address; stable while imem_req=1 and not acked.
- imem_ack  in  1  imem_data valid, request complete.
- imem_data  in  WIDTH  fetched instruction.
- halted  out  1  halt instruction has been consumed by decode; sticky.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0):
  - queue empty, out_valid=0, imem_req=0, fetch_pc=RESET_PC, state=FETCH, halted=0, err=0.
  - imem_req is forced 0 while rst=0.
- FSM states: FETCH, DROP, STOPPED.
- imem_req = (FETCH && count + 0 < DEPTH) || DROP. imem_addr = fetch_pc in FETCH, and the latched pending address in DROP.
- Once imem_req rises it stays high until imem_ack. Its address never changes mid-request, even if a redirect arrives.
- Ack in FETCH with no redirect:
  - enqueue {imem_data, fetch_pc}; fetch_pc += 2 (wraps).
  - If imem_data[WIDTH-1:WIDTH-5] == 5'b00000 (halt), go to STOPPED and issue no further requests.
- Dequeue occurs when out_valid && deq_ready; the head pops.
- Enqueue and dequeue in the same cycle: both occur and count is unchanged.
- Queue full: no request is issued. The queue therefore never overflows.
- Fetch-to-decode latency: data is visible on out_valid the cycle after imem_ack.
- Redirect (redirect_valid=1), which has priority over everything except reset:
  - queue flushed (count=0 next cycle); fetch_pc <= redirect_pc.
  - A dequeue in the same cycle is still considered consumed by decode.
  - Ack in the same cycle: data discarded; next state FETCH.
  - Request pending with no ack this cycle: next state DROP. DROP keeps the old request up until ack, discards that data, then goes to FETCH at the stored redirect_pc.
  - Redirect while in DROP: update the stored target only; stay in DROP.
  - Redirect while STOPPED: resume FETCH at redirect_pc; halted is unaffected.
- halted is set the cycle after a halt entry is dequeued, and stays set until reset.
- err is set, sticky until reset, on any of:
  - imem_ack while imem_req=0;
  - redirect_valid with redirect_pc[0]=1;
  - imem_ack in STOPPED.
- Mid-operation reset discards the queue, any pending request and state.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty, and a FETCH-state ack arrives with no redirect, out_valid/out_instr/out_pc are driven combinationally from imem_data/fetch_pc in the ack cycle.
  - If deq_ready is also 1 that cycle, the entry is not enqueued.
  - Halt detection and fetch_pc increment are unchanged.
- Undefined: no combinational imem-to-decode path. Latency is always 1 cycle.

Decomposition:
- Package fetch_queue_pkg:
  - state enum {FETCH, DROP, STOPPED};
  - HALT_OPCODE = 5'b00000;
  - PC_INCR = 2.
- Sub-module fetchq_fifo: synchronous FIFO of WIDTH*2-bit entries with DEPTH parameter, flush input, count/full/empty outputs, wrap-around pointers.
- The FSM, PC and err logic stay in the top.

Test Plan:
- Reset then imem_ack each cycle, deq_ready=1, RESET_PC=0 → imem_addr 0,2,4,6; out_pc 0,2,4 with out_pc_next 2,4,6; err=0.
- deq_ready=0, DEPTH=4, ack every cycle → exactly 4 enqueues; imem_req=0 while full. Then deq_ready=1 for one cycle → imem_req reasserts with addr 8.
- Request to 0x0010 pending, redirect_pc=0x0040, ack 3 cycles later with 0x1234 → state DROP; 0x1234 never appears on out; next imem_addr=0x0040; queue empty after redirect.
- Redirect to 0x0100 in the same cycle as an ack → acked data discarded; next request at 0x0100 with no DROP cycle.
- Fetch returns 0x0000 (halt) at PC 6 → no further imem_req; halted=1 the cycle after the PC-6 entry dequeues. Later redirect to 0x0020 → fetch resumes at 0x0020.
- imem_ack pulse while imem_req=0, or redirect_pc=0x0003 → err=1 next cycle and stays 1 until rst=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the prefetching fetch unit.
// FSM encoding, halt opcode and PC step.
package fetch_queue_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DROP    = 2'd1,
      STOPPED = 2'd2
   } state_t;

   localparam logic [4:0] HALT_OPCODE = 5'b00000;
   localparam int         PC_INCR     = 2;

   function automatic logic is_halt(input logic [4:0] op);
      return op == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/ack, decode dequeue and redirect signals.
// master = fetch unit, slave = imem/decode/branch environment.
interface fetch_queue_if #(
   parameter int WIDTH = 16
);
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             deq_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_pc_next;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [WIDTH-1:0] imem_data;

   modport master (
      input  redirect_valid, redirect_pc, deq_ready,
      input  imem_ack, imem_data,
      output out_valid, out_instr, out_pc, out_pc_next,
      output imem_req, imem_addr
   );

   modport slave (
      output redirect_valid, redirect_pc, deq_ready,
      output imem_ack, imem_data,
      input  out_valid, out_instr, out_pc, out_pc_next,
      input  imem_req, imem_addr
   );
endinterface

// File: rtl/fetchq_fifo.sv
// fetchq_fifo: synchronous FIFO with flush, wrap-around pointers.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetchq_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [DW-1:0]          din,
   input  logic                   pop,
   output logic [DW-1:0]          dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch unit, req/ack imem, DEPTH-entry queue.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle imem-to-decode bypass.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.master bus,
   output logic          halted,
   output logic          err
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t             state;
   state_t             state_nx;
   logic [WIDTH-1:0]   fetch_pc;
   logic [WIDTH-1:0]   pend_pc;
   logic [2*WIDTH-1:0] q_dout;
   logic [CW-1:0]      count;
   logic               full;
   logic               empty;
   logic               ack_ok;
   logic               fetch_ack;
   logic               byp;
   logic               push;
   logic               pop;
   logic               deq;
   logic               data_halt;

   assign ack_ok    = bus.imem_ack && bus.imem_req;
   assign fetch_ack = ack_ok && state == FETCH && !bus.redirect_valid;
   assign data_halt = is_halt(bus.imem_data[WIDTH-1 -: 5]);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = fetch_ack && empty;
`else
   assign byp = 1'b0;
`endif

   // a bypassed entry taken by decode this cycle never enters the queue
   assign push = fetch_ack && !full && !(byp && bus.deq_ready);
   assign pop  = bus.deq_ready && !empty;
   assign deq  = bus.out_valid && bus.deq_ready;

   assign bus.out_valid   = !empty || byp;
   assign bus.out_instr   = byp ? bus.imem_data : q_dout[2*WIDTH-1:WIDTH];
   assign bus.out_pc      = byp ? fetch_pc : q_dout[WIDTH-1:0];
   assign bus.out_pc_next = bus.out_pc + WIDTH'(PC_INCR);

   fetchq_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.redirect_valid),
      .push  (push),
      .din   ({bus.imem_data, fetch_pc}),
      .pop   (pop),
      .dout  (q_dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= FETCH;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         FETCH: begin
            if (bus.redirect_valid)
               state_nx = (bus.imem_req && !bus.imem_ack) ? DROP : FETCH;
            else if (fetch_ack && data_halt)
               state_nx = STOPPED;
         end
         DROP: begin
            if (bus.imem_ack) state_nx = FETCH;
         end
         STOPPED: begin
            if (bus.redirect_valid) state_nx = FETCH;
         end
         default: state_nx = FETCH;
      endcase
   end

   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = fetch_pc;
      unique case (state)
         FETCH: bus.imem_req = rst && (count < CW'(DEPTH));
         DROP: begin
            bus.imem_req  = rst;
            bus.imem_addr = pend_pc;
         end
         default: ;
      endcase
   end

   // in DROP fetch_pc holds the redirect target, pend_pc the old request
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         pend_pc  <= RESET_PC;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc;
         if (state == FETCH) pend_pc <= fetch_pc;
      end else if (fetch_ack) begin
         fetch_pc <= fetch_pc + WIDTH'(PC_INCR);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         halted <= 1'b0;
      end else if (deq && is_halt(bus.out_instr[WIDTH-1 -: 5])) begin
         halted <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err <= 1'b0;
      end else if ((bus.imem_ack && !bus.imem_req) ||
                   (bus.redirect_valid && bus.redirect_pc[0]) ||
                   (bus.imem_ack && state == STOPPED)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (WIDTH=16, DEPTH=4).
// Behavioural imem responder plus a small reference model of the fetch FSM.
module tb_fetch_queue;
   localparam int W = 16;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } ent_t;

   typedef enum int {M_FETCH, M_DROP, M_STOP} mode_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halted;
   logic err;

   fetch_queue_if #(.WIDTH(W)) bus ();

   fetch_queue #(
      .WIDTH    (W),
      .DEPTH    (4),
      .RESET_PC (16'h0000)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.master),
      .halted (halted),
      .err    (err)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   ent_t        sb[$];
   mode_t       mode;
   logic [15:0] m_pc;
   logic [15:0] m_pend;
   logic [15:0] halt_addr;
   logic        m_halted;
   logic        m_err;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] instr_at(input logic [15:0] a);
      if (a == halt_addr) return 16'h0000;
      if (a == 16'h0010)  return 16'h1234;
      return 16'hA000 ^ a;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst                = 1'b0;
      bus.imem_ack       = 1'b0;
      bus.imem_data      = '0;
      bus.deq_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      @(negedge clk);
      #1;
      chk("req_in_rst", 32'(bus.imem_req), 32'd0);
      chk("valid_in_rst", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      rst      = 1'b1;
      mode     = M_FETCH;
      m_pc     = 16'h0000;
      m_pend   = 16'h0000;
      m_halted = 1'b0;
      m_err    = 1'b0;
      sb.delete();
   endtask

   // one cycle: drive at negedge, check at +1, update model for the next edge
   task automatic step(input bit ack, input bit deq, input bit rv = 1'b0,
                       input logic [15:0] rpc = 16'h0, input bit stray = 1'b0);
      logic        req;
      logic        ackd;
      logic        acc;
      logic [15:0] addr;
      logic [15:0] data;
      bit          exp_req;
      ent_t        e;
      @(negedge clk);
      req     = bus.imem_req;
      addr    = bus.imem_addr;
      exp_req = (mode == M_FETCH && sb.size() < 4) || mode == M_DROP;
      chk("imem_req", 32'(req), 32'(exp_req));
      if (exp_req)
         chk("imem_addr", 32'(addr), 32'(mode == M_DROP ? m_pend : m_pc));
      ackd = stray || (ack && req);
      data = instr_at(addr);
      bus.imem_ack       = ackd;
      bus.imem_data      = data;
      bus.deq_ready      = deq;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("err", 32'(err), 32'(m_err));
      if (bus.out_valid && deq && sb.size() != 0) begin
         e = sb.pop_front();
         chk("out_instr", 32'(bus.out_instr), 32'(e.instr));
         chk("out_pc", 32'(bus.out_pc), 32'(e.pc));
         chk("out_pc_next", 32'(bus.out_pc_next), 32'(e.pc + 16'd2));
         if (e.instr[15:11] == 5'b00000) m_halted = 1'b1;
      end
      acc = ackd && req && !rv && mode == M_FETCH;
      if ((ackd && !req) || (rv && rpc[0]) || (ackd && mode == M_STOP))
         m_err = 1'b1;
      if (rv) begin
         sb.delete();
         if (mode == M_FETCH && req && !ackd) begin
            mode   = M_DROP;
            m_pend = m_pc;
         end else if (!(mode == M_DROP && !ackd)) begin
            mode = M_FETCH;
         end
         m_pc = rpc;
      end else if (acc) begin
         e.instr = data;
         e.pc    = m_pc;
         sb.push_back(e);
         m_pc = m_pc + 16'd2;
         if (data[15:11] == 5'b00000) mode = M_STOP;
      end else if (mode == M_DROP && ackd) begin
         mode = M_FETCH;
      end
   endtask

   initial begin
      halt_addr          = 16'hFFFF;
      bus.imem_ack       = 1'b0;
      bus.imem_data      = '0;
      bus.deq_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // streaming fetch with decode always ready
      do_reset();
      repeat (6) step(1, 1);

      // fill to full, then a single dequeue reopens fetch at 8
      do_reset();
      repeat (6) step(1, 0);
      step(0, 1);
      step(1, 1);
      chk("refill_pc", 32'(m_pc), 32'h000A);
      repeat (5) step(0, 1);

      // redirect while the 0x0010 request is pending goes through DROP
      do_reset();
      repeat (8) step(1, 1);
      step(0, 1);
      step(0, 1, 1, 16'h0040);
      chk("drop_mode", 32'(mode == M_DROP), 32'd1);
      step(0, 1);
      step(0, 1);
      step(1, 1);
      repeat (3) step(1, 1);

      // redirect coinciding with an ack: no DROP cycle
      step(1, 1, 1, 16'h0100);
      repeat (3) step(1, 1);

      // halt at PC 6 stops fetch; redirect resumes at 0x0020
      halt_addr = 16'h0006;
      do_reset();
      repeat (6) step(1, 0);
      repeat (6) step(0, 1);
      step(0, 1, 1, 16'h0020);
      repeat (3) step(1, 1);
      halt_addr = 16'hFFFF;

      // stray ack while full sets err; reset clears it
      do_reset();
      repeat (5) step(1, 0);
      step(0, 0, 0, 16'h0, 1);
      repeat (2) step(0, 0);
      do_reset();
      step(1, 1);

      // odd redirect target sets err
      step(0, 1, 1, 16'h0003);
      repeat (2) step(1, 1);
      do_reset();
      step(0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
